// File: rtl/dma_job_scheduler.sv
// Round-robin owner of the accelerator DMA: programs descriptor 0 and control over
// AXI-Lite for each granted job, waits for completion or timeout, then clears go.
package dma_axil_pkg;
    typedef struct packed {
        logic [31:0] awaddr;
        logic [2:0]  awprot;
        logic [3:0]  awid;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wvalid;
        logic        bready;
        logic [31:0] araddr;
        logic [2:0]  arprot;
        logic        arvalid;
        logic        rready;
    } s_axil_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rvalid;
    } s_axil_miso_t;
endpackage

module dma_job_scheduler
    import dma_axil_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter int          TIMEOUT_CYC    = 65535,
    parameter logic [31:0] OFF_SRC        = 32'h10,
    parameter logic [31:0] OFF_DST        = 32'h18,
    parameter logic [31:0] OFF_BYTES      = 32'h20,
    parameter logic [31:0] OFF_CFG        = 32'h28,
    parameter logic [31:0] OFF_CTRL       = 32'h00,
    parameter logic [31:0] CFG_VAL        = 32'h4,
    parameter logic [31:0] CTRL_GO_VAL    = 32'h1F,
    parameter logic [31:0] CTRL_ABORT_VAL = 32'h2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*32-1:0]   req_src_i,
    input  logic [NUM_REQ*32-1:0]   req_bytes_i,
    output logic [NUM_REQ-1:0]      grant_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [NUM_REQ-1:0]      err_o,
    output logic                    busy_o,
    output s_axil_mosi_t            csr_mosi_o,
    input  s_axil_miso_t            csr_miso_i,
    input  logic                    dma_done_i,
    input  logic                    dma_error_i
);
    localparam int            IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW:0]   NREQ_W = (IW+1)'(NUM_REQ);

    typedef enum logic [2:0] {IDLE, AW_W, B, WAIT_DONE, RESP} state_t;
    typedef enum logic [2:0] {W_SRC, W_DST, W_BYTES, W_CFG, W_GO, W_ABORT, W_CLR} widx_t;

    state_t             state_q, state_d;
    widx_t              widx_q, widx_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [31:0]        src_q, src_d, bytes_q, bytes_d;
    logic               aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic               err_q, err_d;
    logic [15:0]        tmo_q, tmo_d;
    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic [IW:0]        cand;
    logic               unused_miso;

    assign unused_miso = ^{csr_miso_i.arready, csr_miso_i.rdata, csr_miso_i.rresp, csr_miso_i.rvalid};

    function automatic logic [31:0] wr_addr(widx_t w);
        case (w)
            W_SRC:   return OFF_SRC;
            W_DST:   return OFF_DST;
            W_BYTES: return OFF_BYTES;
            W_CFG:   return OFF_CFG;
            default: return OFF_CTRL;
        endcase
    endfunction

    function automatic logic [31:0] wr_data(widx_t w, logic [31:0] s, logic [31:0] b);
        case (w)
            W_SRC:   return s;
            W_BYTES: return b;
            W_CFG:   return CFG_VAL;
            W_GO:    return CTRL_GO_VAL;
            W_ABORT: return CTRL_ABORT_VAL;
            default: return 32'h0;
        endcase
    endfunction

    // First requester strictly after the last owner, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!pick_vld && req_valid_i[cand[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        src_d     = src_q;
        bytes_d   = bytes_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    rr_ptr_d       = pick;
                    grant_d        = '0;
                    grant_d[pick]  = 1'b1;
                    src_d          = req_src_i[32*pick +: 32];
                    bytes_d        = req_bytes_i[32*pick +: 32];
                    err_d          = 1'b0;
                    if (req_bytes_i[32*pick +: 32] == 32'h0) begin
                        state_d = RESP;
                    end else begin
                        state_d   = AW_W;
                        widx_d    = W_SRC;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end
                end
            end
            AW_W: begin
                aw_pend_d = aw_pend_q & ~csr_miso_i.awready;
                w_pend_d  = w_pend_q & ~csr_miso_i.wready;
                if (!aw_pend_d && !w_pend_d) state_d = B;
            end
            B: begin
                if (csr_miso_i.bvalid) begin
                    state_d   = AW_W;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    if (widx_q == W_CLR) begin
                        state_d   = RESP;
                        aw_pend_d = 1'b0;
                        w_pend_d  = 1'b0;
                        if (csr_miso_i.bresp != 2'b00) err_d = 1'b1;
                    end else if (csr_miso_i.bresp != 2'b00) begin
                        err_d  = 1'b1;
                        widx_d = W_CLR;
                    end else if (widx_q == W_GO) begin
                        state_d   = WAIT_DONE;
                        aw_pend_d = 1'b0;
                        w_pend_d  = 1'b0;
                        tmo_d     = '0;
                    end else if (widx_q == W_ABORT) begin
                        widx_d = W_CLR;
                    end else begin
                        widx_d = widx_t'(widx_q + 3'd1);
                    end
                end
            end
            WAIT_DONE: begin
                tmo_d = tmo_q + 16'd1;
                if (dma_done_i || dma_error_i || ({1'b0, tmo_q} + 17'd1 == 17'(TIMEOUT_CYC))) begin
                    state_d   = AW_W;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    widx_d    = W_CLR;
                    if (!dma_done_i) err_d = 1'b1;
                    if (!dma_done_i && !dma_error_i) widx_d = W_ABORT;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            widx_q    <= W_SRC;
            rr_ptr_q  <= IW'(NUM_REQ-1);
            grant_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        src_q   <= src_d;
        bytes_q <= bytes_d;
    end

    // Outputs are forced quiet while reset is asserted, even mid-job.
    always_comb begin
        csr_mosi_o        = '0;
        csr_mosi_o.rready = 1'b1;
        req_ready_o       = '0;
        grant_o           = '0;
        done_o            = '0;
        err_o             = '0;
        busy_o            = 1'b0;
        if (!rst) begin
            if (state_q == IDLE && pick_vld) req_ready_o[pick] = 1'b1;
            grant_o            = grant_q;
            busy_o             = (state_q != IDLE);
            csr_mosi_o.awvalid = (state_q == AW_W) && aw_pend_q;
            csr_mosi_o.wvalid  = (state_q == AW_W) && w_pend_q;
            csr_mosi_o.awaddr  = wr_addr(widx_q);
            csr_mosi_o.wdata   = wr_data(widx_q, src_q, bytes_q);
            csr_mosi_o.wstrb   = 4'hF;
            csr_mosi_o.bready  = (state_q == B);
            if (state_q == RESP) begin
                done_o = grant_q;
                err_o  = err_q ? grant_q : '0;
            end
        end
    end
endmodule
